clk_freq_monitor: RTL

- Sits directly downstream of the 256:1 clock divider, in the clk_in domain. Samples the divided clock (clk_mon) and measures its period in clk_in cycles.
- Declares lock after LOCK_CNT consecutive in-tolerance periods.
- Once locked, flags a too-fast, too-slow or stopped divided clock to the system controller.

---
 rtl/clk_freq_monitor.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: measures the period of a divided clock (clk_mon) in
// clk_in cycles, declares lock after LOCK_CNT consecutive in-tolerance
// periods and, once locked, flags a too-fast, too-slow or stopped clk_mon.
// Optional build macro CLK_FREQ_MONITOR_IRQ_EN adds a sticky interrupt
// (irq, cleared by irq_clr) raised on every LOCKED -> FAULT transition.
module clk_freq_monitor #(
    parameter int EXP_PERIOD = 256,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int CNT_W      = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             clk_mon,
`ifdef CLK_FREQ_MONITOR_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic             mon_edge,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0]    P_LO     = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0]    P_HI     = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  T_OUT    = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              s1_r, s2_r, s3_r;
    logic              edge_s;
    logic              mon_edge_r;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [GOOD_W-1:0] good_cnt_r, good_cnt_nxt_s;
    logic [CNT_W:0]    p_s;
    logic              p_fast_s, p_slow_s, p_good_s;
    logic              timeout_s;
    logic              period_upd_s;
    logic [CNT_W-1:0]  period_r;
    logic              period_valid_r;
    logic              locked_r, locked_nxt_s;
    logic              fault_r, fault_nxt_s;
    logic [1:0]        fault_code_r, fault_code_nxt_s;

    // Period as seen on an edge cycle, computed one bit wider so it never wraps
    assign edge_s       = s2_r & ~s3_r;
    assign p_s          = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign p_fast_s     = (p_s < P_LO);
    assign p_slow_s     = (p_s > P_HI);
    assign p_good_s     = ~p_fast_s & ~p_slow_s;
    assign timeout_s    = (cnt_r == T_OUT) & ~edge_s;
    assign period_upd_s = enable & edge_s &
                          ((state_r == ST_MEASURE) | (state_r == ST_LOCKED));

    // Three-flop synchronizer and registered edge pulse; ignores enable
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1_r       <= 1'b0;
            s2_r       <= 1'b0;
            s3_r       <= 1'b0;
            mon_edge_r <= 1'b0;
        end else begin
            s1_r       <= clk_mon;
            s2_r       <= s1_r;
            s3_r       <= s2_r;
            mon_edge_r <= edge_s;
        end
    end

    // State register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; disable wins over everything, an edge wins over timeout
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_ARM;
                ST_ARM: begin
                    if (edge_s) state_nxt_s = ST_MEASURE;
                    else        state_nxt_s = ST_ARM;
                end
                ST_MEASURE: begin
                    if (edge_s && p_good_s && ((good_cnt_r + GOOD_W'(1)) == GOOD_TGT))
                        state_nxt_s = ST_LOCKED;
                    else
                        state_nxt_s = ST_MEASURE;
                end
                ST_LOCKED: begin
                    if (edge_s) begin
                        if (p_fast_s || p_slow_s) state_nxt_s = ST_FAULT;
                        else                      state_nxt_s = ST_LOCKED;
                    end else if (timeout_s) begin
                        state_nxt_s = ST_FAULT;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end
                ST_FAULT: state_nxt_s = ST_FAULT;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Next values for counters and status outputs
    always_comb begin
        cnt_nxt_s        = cnt_r;
        good_cnt_nxt_s   = good_cnt_r;
        locked_nxt_s     = 1'b0;
        fault_nxt_s      = 1'b0;
        fault_code_nxt_s = 2'b00;

        if (!enable || (state_r == ST_IDLE)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (edge_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end

        if (!enable || (state_r != ST_MEASURE)) begin
            good_cnt_nxt_s = {GOOD_W{1'b0}};
        end else if (edge_s) begin
            if (p_good_s) good_cnt_nxt_s = good_cnt_r + GOOD_W'(1);
            else          good_cnt_nxt_s = {GOOD_W{1'b0}};
        end else begin
            good_cnt_nxt_s = good_cnt_r;
        end

        locked_nxt_s = (state_nxt_s == ST_LOCKED);
        fault_nxt_s  = (state_nxt_s == ST_FAULT);

        // Code is captured on entry to FAULT and then held while sticky
        if (state_nxt_s != ST_FAULT) begin
            fault_code_nxt_s = 2'b00;
        end else if (state_r == ST_FAULT) begin
            fault_code_nxt_s = fault_code_r;
        end else if (edge_s && p_fast_s) begin
            fault_code_nxt_s = 2'b01;
        end else begin
            fault_code_nxt_s = 2'b10;
        end
    end

    // Counter and output registers; period keeps its value across disable
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_r          <= {CNT_W{1'b0}};
            good_cnt_r     <= {GOOD_W{1'b0}};
            period_r       <= {CNT_W{1'b0}};
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            fault_r        <= 1'b0;
            fault_code_r   <= 2'b00;
        end else begin
            cnt_r          <= cnt_nxt_s;
            good_cnt_r     <= good_cnt_nxt_s;
            period_valid_r <= period_upd_s;
            locked_r       <= locked_nxt_s;
            fault_r        <= fault_nxt_s;
            fault_code_r   <= fault_code_nxt_s;
            if (period_upd_s) period_r <= p_s[CNT_W-1:0];
            else              period_r <= period_r;
        end
    end

`ifdef CLK_FREQ_MONITOR_IRQ_EN
    logic irq_r;
    logic irq_set_s;

    assign irq_set_s = (state_r == ST_LOCKED) && (state_nxt_s == ST_FAULT);

    // Sticky interrupt: a new fault wins over a coincident clear
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_r <= 1'b1;
        end else if (irq_clr) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq = irq_r;
`endif

    assign mon_edge     = mon_edge_r;
    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign locked       = locked_r;
    assign fault        = fault_r;
    assign fault_code   = fault_code_r;

endmodule
